// File: rtl/l2_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : l2_arbiter
// Purpose  : Round-robin share of one line-wide memory port between the
//            I-cache miss port and the D-cache miss/writeback port.
// Revision : 1.0  initial release
// ============================================================================
module l2_arbiter #(
    parameter int LINE_W   = 256,
    parameter int S_OFFSET = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [31:0]       i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [31:0]       d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              m_read,
    output logic              m_write,
    output logic [31:0]       m_address,
    output logic [LINE_W-1:0] m_wdata,
    input  logic [LINE_W-1:0] m_rdata,
    input  logic              m_resp
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [31:0] c_line_mask = ~((32'd1 << S_OFFSET) - 32'd1);

    state_t            r_state, w_state_nxt;
    logic              r_last_d, w_last_d_nxt;
    logic              r_gnt_d, w_gnt_d_nxt;
    logic              w_m_read_nxt, w_m_write_nxt;
    logic [31:0]       w_m_address_nxt;
    logic [LINE_W-1:0] w_m_wdata_nxt, w_i_rdata_nxt, w_d_rdata_nxt;
    logic              w_i_resp_nxt, w_d_resp_nxt;
    logic              w_pend_i, w_pend_d, w_pick_d;

    assign w_pend_i = i_read;
    assign w_pend_d = d_read | d_write;
    // D wins when alone, or on a tie when I was the last one served.
    assign w_pick_d = w_pend_d & (~w_pend_i | ~r_last_d);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_last_d  <= 1'b1;
            r_gnt_d   <= 1'b0;
            m_read    <= 1'b0;
            m_write   <= 1'b0;
            m_address <= '0;
            m_wdata   <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
            i_resp    <= 1'b0;
            d_resp    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_last_d  <= w_last_d_nxt;
            r_gnt_d   <= w_gnt_d_nxt;
            m_read    <= w_m_read_nxt;
            m_write   <= w_m_write_nxt;
            m_address <= w_m_address_nxt;
            m_wdata   <= w_m_wdata_nxt;
            i_rdata   <= w_i_rdata_nxt;
            d_rdata   <= w_d_rdata_nxt;
            i_resp    <= w_i_resp_nxt;
            d_resp    <= w_d_resp_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_last_d_nxt    = r_last_d;
        w_gnt_d_nxt     = r_gnt_d;
        w_m_read_nxt    = m_read;
        w_m_write_nxt   = m_write;
        w_m_address_nxt = m_address;
        w_m_wdata_nxt   = m_wdata;
        w_i_rdata_nxt   = i_rdata;
        w_d_rdata_nxt   = d_rdata;
        w_i_resp_nxt    = 1'b0;
        w_d_resp_nxt    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pend_i | w_pend_d) begin
                    w_state_nxt  = BUSY;
                    w_last_d_nxt = w_pick_d;
                    w_gnt_d_nxt  = w_pick_d;
                    if (w_pick_d) begin
                        // A simultaneous read and write resolves to the writeback.
                        w_m_write_nxt   = d_write;
                        w_m_read_nxt    = ~d_write;
                        w_m_address_nxt = d_address & c_line_mask;
                        if (d_write) begin
                            w_m_wdata_nxt = d_wdata;
                        end
                    end else begin
                        w_m_read_nxt    = 1'b1;
                        w_m_write_nxt   = 1'b0;
                        w_m_address_nxt = i_address & c_line_mask;
                    end
                end
            end
            BUSY: begin
                if (m_resp) begin
                    w_state_nxt   = RESP;
                    w_m_read_nxt  = 1'b0;
                    w_m_write_nxt = 1'b0;
                    if (r_gnt_d) begin
                        w_d_resp_nxt = 1'b1;
                        if (m_read) begin
                            w_d_rdata_nxt = m_rdata;
                        end
                    end else begin
                        w_i_resp_nxt  = 1'b1;
                        w_i_rdata_nxt = m_rdata;
                    end
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
